ram_arbiter: RTL

- Two-master arbiter that shares the single basic_ram port between the file loader/debug master (m0) and the ARMv4 core (m1).
- Replaces the combinational ld_file mux.
- Serialises accesses with a grant/ready handshake, supports fixed-priority or round-robin arbitration, and blocks the core while loading.
- Includes a watchdog so that a missing mem_done cannot hang the core.

---
 rtl/ram_arbiter_if.sv | 39 +++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_if
// Purpose : Memory access bundle shared by the requesters, the arbiter and
//           the RAM port. The requester side drives the strobes, address and
//           write data. The responder side returns read data and a completion
//           flag.
// Signals : cs, we, oe      access strobes (requester -> responder)
//           addr, d_in      address / write data (requester -> responder)
//           data_size       access size (requester -> responder)
//           d_out           read data (responder -> requester)
//           ready           access complete; on the RAM side this is mem_done
// Modports: master = requester side, slave = responder side
// Revision: 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cs;
  logic              we;
  logic              oe;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_in;
  logic [1:0]        data_size;
  logic [DATA_W-1:0] d_out;
  logic              ready;

  modport master (
    output cs, we, oe, addr, d_in, data_size,
    input  d_out, ready
  );

  modport slave (
    input  cs, we, oe, addr, d_in, data_size,
    output d_out, ready
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Shares one RAM port between the loader/debug master (m0) and the
//           core (m1). Accesses are serialised as IDLE -> ACCESS -> RELEASE.
//           Ties are resolved by fixed priority (m0) or by round-robin. A
//           watchdog forces the release of an access that never sees mem_done.
// Ports   : clk          system clock, rising edge
//           rst          asynchronous, active-low reset
//           m1_block     1 = ignore new m1 requests (loader mode)
//           m0, m1       requester buses (slave side of the arbiter)
//           ram          RAM bus (master side); ram.ready is mem_done
//           grant        one-hot owner {m1,m0}; 00 = none
//           busy         arbiter is not idle
//           timeout_err  one-cycle pulse when the watchdog releases an access
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m1_block,
  ram_arbiter_if.slave        m0,
  ram_arbiter_if.slave        m1,
  ram_arbiter_if.master       ram,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             last_m1_q, last_m1_d;  // 1 = previous owner was m1

  logic req0;
  logic req1;
  logic wdog_expired;

  // ram.ready has priority: a done arriving on the last watchdog cycle
  // completes normally rather than being reported as a timeout.
  assign wdog_expired = (state_q == ST_ACCESS) && !ram.ready && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      wdog_q    <= '0;
      last_m1_q <= 1'b1;   // m0 wins the first round-robin tie
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wdog_q    <= wdog_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wdog_d    = wdog_q;
    last_m1_d = last_m1_q;
    req0      = m0.cs;
    req1      = m1.cs & ~m1_block;

    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (req0 && req1) begin
          if ((RR_MODE != 0) && !last_m1_q) begin
            grant_d = 2'b10;
          end else begin
            grant_d = 2'b01;
          end
          state_d = ST_ACCESS;
        end else if (req0) begin
          grant_d = 2'b01;
          state_d = ST_ACCESS;
        end else if (req1) begin
          grant_d = 2'b10;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (ram.ready || wdog_expired) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_m1_d = grant_q[1];
        wdog_d    = '0;
        grant_d   = 2'b00;
        state_d   = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        wdog_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus steering: only the owner is connected, and only while in ACCESS.
  // Everything else is held at zero so the RAM sees cs drop as soon as the
  // state leaves ACCESS (including an asynchronous reset).
  always_comb begin
    ram.cs        = 1'b0;
    ram.we        = 1'b0;
    ram.oe        = 1'b0;
    ram.addr      = '0;
    ram.d_in      = '0;
    ram.data_size = 2'b00;
    m0.ready      = 1'b0;
    m0.d_out      = '0;
    m1.ready      = 1'b0;
    m1.d_out      = '0;
    timeout_err   = 1'b0;

    if (state_q == ST_ACCESS) begin
      timeout_err = wdog_expired;
      if (grant_q[1]) begin
        ram.cs        = m1.cs;
        ram.we        = m1.we;
        ram.oe        = m1.oe;
        ram.addr      = m1.addr;
        ram.d_in      = m1.d_in;
        ram.data_size = m1.data_size;
        m1.ready      = ram.ready | wdog_expired;
        m1.d_out      = wdog_expired ? '0 : ram.d_out;
      end else if (grant_q[0]) begin
        ram.cs        = m0.cs;
        ram.we        = m0.we;
        ram.oe        = m0.oe;
        ram.addr      = m0.addr;
        ram.d_in      = m0.d_in;
        ram.data_size = m0.data_size;
        m0.ready      = ram.ready | wdog_expired;
        m0.d_out      = wdog_expired ? '0 : ram.d_out;
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire
